// File: rtl/bram_fifo_ctrl_if.sv
// Stream and BRAM bus bundle for bram_fifo_ctrl.
// The master modport is the controller's view; the slave modport is the
// surrounding environment (upstream producer, downstream consumer, BRAM).
interface bram_fifo_ctrl_if #(
  parameter int ALEN = 4,
  parameter int DLEN = 8
);
  logic            s_valid;
  logic            s_ready;
  logic [DLEN-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DLEN-1:0] m_data;
  logic            mem_wen;
  logic [ALEN-1:0] mem_waddr;
  logic [DLEN-1:0] mem_wdata;
  logic            mem_ren;
  logic [ALEN-1:0] mem_raddr;
  logic [DLEN-1:0] mem_rdata;
  logic            mem_rvalid;
  logic [ALEN:0]   mem_count;
  logic            err;

  modport master (
    input  s_valid, s_data, m_ready, mem_rdata, mem_rvalid,
    output s_ready, m_valid, m_data, mem_wen, mem_waddr, mem_wdata,
           mem_ren, mem_raddr, mem_count, err
  );

  modport slave (
    output s_valid, s_data, m_ready, mem_rdata, mem_rvalid,
    input  s_ready, m_valid, m_data, mem_wen, mem_waddr, mem_wdata,
           mem_ren, mem_raddr, mem_count, err
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Stream FIFO controller backed by an external block RAM.
// Beats are written to BRAM at a wrapping write pointer, prefetched through
// the BRAM read port under credit control, and served from a small register
// output buffer so any read latency is tolerated.
module bram_fifo_ctrl #(
  parameter int ALEN = 4,
  parameter int DLEN = 8,
  parameter int OBUF = 4
) (
  input  logic              clk,
  input  logic              rstn,
  bram_fifo_ctrl_if.master  io
);
  localparam int OW = $clog2(OBUF);
  localparam int CW = OW + 1;
  localparam logic [ALEN:0]   FULL   = {1'b1, {ALEN{1'b0}}};
  localparam logic [CW-1:0]   OBUF_W = CW'(OBUF);

  logic [ALEN-1:0] wptr_q, wptr_d;
  logic [ALEN-1:0] rptr_q, rptr_d;
  logic [ALEN:0]   mem_count_q, mem_count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   obuf_count_q, obuf_count_d;
  logic [OW-1:0]   head_q, head_d;
  logic [OW-1:0]   tail_q, tail_d;
  logic [DLEN-1:0] obuf_q [OBUF];
  logic [DLEN-1:0] obuf_d [OBUF];
  logic            err_q, err_d;

  logic [CW-1:0]   credit;
  logic            wr, rd, push, pop;

  // Handshakes and BRAM requests from registered state; reset gates outputs.
  always_comb begin
    credit       = OBUF_W - obuf_count_q - inflight_q;
    io.s_ready   = rstn && (mem_count_q != FULL);
    wr           = io.s_valid && io.s_ready;
    io.mem_wen   = wr;
    io.mem_waddr = wptr_q;
    io.mem_wdata = io.s_data;
    rd           = rstn && (mem_count_q != '0) && (credit != '0);
    io.mem_ren   = rd;
    io.mem_raddr = rptr_q;
    io.m_valid   = rstn && (obuf_count_q != '0);
    io.m_data    = obuf_q[head_q];
    pop          = io.m_valid && io.m_ready;
    push         = io.mem_rvalid && (inflight_q != '0);
    io.mem_count = mem_count_q;
    io.err       = err_q;
  end

  // Next-state: pointers, occupancy counters, buffer contents, sticky error.
  always_comb begin
    wptr_d = wr ? wptr_q + ALEN'(1) : wptr_q;
    rptr_d = rd ? rptr_q + ALEN'(1) : rptr_q;

    mem_count_d = mem_count_q;
    case ({wr, rd})
      2'b10:   mem_count_d = mem_count_q + (ALEN+1)'(1);
      2'b01:   mem_count_d = mem_count_q - (ALEN+1)'(1);
      default: mem_count_d = mem_count_q;
    endcase

    inflight_d = inflight_q;
    case ({rd, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    obuf_d = obuf_q;
    if (push) obuf_d[tail_q] = io.mem_rdata;
    tail_d = push ? tail_q + OW'(1) : tail_q;
    head_d = pop  ? head_q + OW'(1) : head_q;

    obuf_count_d = obuf_count_q;
    case ({push, pop})
      2'b10:   obuf_count_d = obuf_count_q + CW'(1);
      2'b01:   obuf_count_d = obuf_count_q - CW'(1);
      default: obuf_count_d = obuf_count_q;
    endcase

    // A return with nothing outstanding is dropped and flagged.
    err_d = err_q | (io.mem_rvalid && (inflight_q == '0));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      mem_count_q  <= '0;
      inflight_q   <= '0;
      obuf_count_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      obuf_q       <= '{default: '0};
      err_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      mem_count_q  <= mem_count_d;
      inflight_q   <= inflight_d;
      obuf_count_q <= obuf_count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      obuf_q       <= obuf_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: BRAM model with selectable latency, a queue-based
// occupancy model checked every cycle, and directed scenarios with literal
// expectations.
module tb_bram_fifo_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.ALEN(4), .DLEN(8)) bus ();

  bram_fifo_ctrl #(.ALEN(4), .DLEN(8), .OBUF(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  bit          started = 1'b0;
  int unsigned t_first = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- BRAM model: write on wen, read data L cycles after ren
  logic [7:0] ram [16];
  logic [3:0] rv_pipe = '0;
  logic [7:0] rd_pipe [4];
  logic [1:0] lsel = 2'd0;      // latency = lsel + 1
  logic       inject = 1'b0;

  always @(posedge clk) begin
    if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
    rv_pipe    <= {rv_pipe[2:0], bus.mem_ren};
    rd_pipe[0] <= ram[bus.mem_raddr];
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rvalid = rv_pipe[lsel] | inject;
  assign bus.mem_rdata  = rd_pipe[lsel];

  // ---------------- Occupancy model: words live in BRAM, then flight, then buffer
  logic [7:0]  q_mem [$];
  logic [7:0]  q_fly [$];
  logic [7:0]  q_buf [$];
  bit          m_err = 1'b0;
  int unsigned wcnt = 0, rcnt = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  out_log [$];
  int unsigned out_cyc [$];

  always @(negedge clk) begin
    bit es, ew, er, emv;
    if (started) begin
      if (!rstn) begin
        es = 0; ew = 0; er = 0; emv = 0;
      end else begin
        es  = (q_mem.size() != 16);
        ew  = bus.s_valid && es;
        er  = (q_mem.size() != 0) && ((4 - q_buf.size() - q_fly.size()) != 0);
        emv = (q_buf.size() != 0);
      end
      chk("s_ready",   bus.s_ready, es);
      chk("mem_wen",   bus.mem_wen, ew);
      chk("mem_ren",   bus.mem_ren, er);
      chk("m_valid",   bus.m_valid, emv);
      chk("err",       bus.err, m_err);
      chk("mem_count", bus.mem_count, q_mem.size());
      if (ew) begin
        chk("mem_waddr", bus.mem_waddr, 4'(wcnt));
        chk("mem_wdata", bus.mem_wdata, bus.s_data);
      end
      if (er) chk("mem_raddr", bus.mem_raddr, 4'(rcnt));
      if (emv) chk("m_data", bus.m_data, q_buf[0]);
      if (prev_stall) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data",  bus.m_data, prev_data);
      end
      prev_stall = rstn && bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (rstn && bus.m_valid && bus.m_ready) begin
        out_log.push_back(bus.m_data);
        out_cyc.push_back(cyc);
      end

      if (!rstn) begin
        q_mem.delete(); q_fly.delete(); q_buf.delete();
        m_err = 1'b0; wcnt = 0; rcnt = 0;
      end else begin
        if (emv && bus.m_ready) void'(q_buf.pop_front());
        if (bus.mem_rvalid) begin
          if (q_fly.size() != 0) q_buf.push_back(q_fly.pop_front());
          else m_err = 1'b1;
        end
        if (er) begin q_fly.push_back(q_mem.pop_front()); rcnt++; end
        if (ew) begin q_mem.push_back(bus.s_data); wcnt++; end
      end
    end
  end

  // ---------------- Stimulus helpers
  function automatic logic [7:0] data_of(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(8'h40 + i);
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  task automatic run(input int nb, input int kind, input bit rnd, input int want_out);
    int n = 0;
    int guard = 0;
    while ((n < nb || out_log.size() < want_out) && guard < 3000) begin
      @(posedge clk); #1;
      bus.s_valid = (n < nb);
      bus.s_data  = data_of(kind, n);
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        if (n == 0) t_first = cyc;
        n++;
      end
      guard++;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    chk("run_timeout", 32'(guard < 3000), 1);
  endtask

  task automatic idle_wait();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    bus.m_ready = 1'b0;

    // Reset held with s_valid asserted
    @(posedge clk);
    started = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_mem_wen", bus.mem_wen, 0);
      chk("rst_mem_ren", bus.mem_ren, 0);
      chk("rst_err",     bus.err, 0);
      chk("rst_count",   bus.mem_count, 0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.s_valid = 1'b0;
    idle_wait();

    // Single beat, L=1: wen at t, ren at t+1, m_valid at t+3
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    @(negedge clk);
    chk("single_wen",   bus.mem_wen, 1);
    chk("single_waddr", bus.mem_waddr, 0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("single_ren_t1", bus.mem_ren, 1);
    @(negedge clk);
    chk("single_mvalid_t2", bus.m_valid, 0);
    @(negedge clk);
    chk("single_mvalid_t3", bus.m_valid, 1);
    chk("single_mdata_t3",  bus.m_data, 8'hA5);
    idle_wait();

    // Fill: 16 in BRAM + 4 buffered, then drain in order
    bus.m_ready = 1'b0;
    out_log.delete(); out_cyc.delete();
    run(20, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("fill_s_ready", bus.s_ready, 0);
    chk("fill_count",   bus.mem_count, 16);
    chk("fill_m_valid", bus.m_valid, 1);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    g = 0;
    while (!bus.mem_ren && g < 20) begin @(negedge clk); g++; end
    chk("fill_refill_seen", bus.mem_ren, 1);
    chk("fill_sready_at_refill", bus.s_ready, 0);
    @(negedge clk);
    chk("fill_sready_after_refill", bus.s_ready, 1);
    g = 0;
    while (out_log.size() < 20 && g < 200) begin @(negedge clk); g++; end
    chk("fill_out_count", out_log.size(), 20);
    for (int i = 0; i < 20 && i < out_log.size(); i++) chk("fill_order", out_log[i], 8'(i));
    idle_wait();

    // Streaming wrap with 2-cycle BRAM latency: no bubbles after first beat
    lsel = 2'd1;
    out_log.delete(); out_cyc.delete();
    bus.m_ready = 1'b1;
    run(40, 1, 0, 40);
    chk("stream_out_count", out_log.size(), 40);
    for (int i = 0; i < 40 && i < out_log.size(); i++) begin
      chk("stream_order", out_log[i], 8'(8'h40 + i));
      chk("stream_timing", out_cyc[i] - t_first, 4 + i);
    end
    idle_wait();

    // Random backpressure over 100 beats, L=1
    lsel = 2'd0;
    out_log.delete(); out_cyc.delete();
    run(100, 2, 1, 100);
    bus.m_ready = 1'b1;
    chk("bp_out_count", out_log.size(), 100);
    for (int i = 0; i < 100 && i < out_log.size(); i++) chk("bp_order", out_log[i], data_of(2, i));
    chk("bp_err", bus.err, 0);
    idle_wait();

    // Spurious return with nothing in flight
    @(negedge clk);
    chk("spur_err_before", bus.err, 0);
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    chk("spur_err_set",  bus.err, 1);
    chk("spur_m_valid",  bus.m_valid, 0);
    chk("spur_count",    bus.mem_count, 0);
    repeat (3) @(negedge clk);
    chk("spur_err_sticky", bus.err, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("spur_err_cleared", bus.err, 0);
    idle_wait();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
